// File: rtl/uart_tx_seq.sv
// Message-sequencing UART transmitter: walks a downstream character counter
// and serialises MSG_LEN bytes as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_seq #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MSG_LEN      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] car_cont,
  input  logic [7:0] data_in,
  output logic       cont_rst,
  output logic       cont_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    NEXT,
    DONE
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  CHAR_LAST = 6'(MSG_LEN - 1);

  state_t      state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_q, tx_n;
  logic        bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    bit_end   = (clk_cnt == BIT_LAST);

    case (state)
      IDLE:  if (start) state_n = CLEAR;
      CLEAR: state_n = LOAD;
      LOAD: begin
        shreg_n   = data_in;
        clk_cnt_n = '0;
        bit_idx_n = '0;
        state_n   = START;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = STOP;
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = NEXT;
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
      NEXT:    state_n = (car_cont == CHAR_LAST) ? DONE : LOAD;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // tx is registered from the upcoming state so the line changes in step with the FSM
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = ^shreg_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    cont_rst = (state == CLEAR);
    cont_en  = (state == NEXT) && (car_cont != CHAR_LAST);
    done     = (state == DONE);
    tx       = tx_q;
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: per-cycle comparison against a message-level waveform model,
// plus literal checks on lengths, pulse counts, bit values and reset behaviour.
module tb_uart_tx_seq;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int BUSY3 = 140;
  localparam int BUSY1 = 48;
  localparam int LOW1  = 40;
`else
  localparam int BUSY3 = 128;
  localparam int BUSY1 = 44;
  localparam int LOW1  = 36;
`endif

  typedef struct packed {
    logic busy;
    logic tx;
    logic done;
    logic rst;
    logic en;
  } rec_t;

  localparam rec_t IDLE_R = 5'b01000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [5:0] cnt0 = 6'd2, cnt1 = 6'd5;
  logic [7:0] data0, data1;
  logic rst0, en0, tx0, busy0, done0;
  logic rst1, en1, tx1, busy1, done1;
  logic [7:0] rom0 [0:63];
  logic [7:0] rom1 [0:63];

  int total = 0, bad = 0, shown = 0;

  always #5 clk = ~clk;

  uart_tx_seq #(.CLKS_PER_BIT(CPB), .MSG_LEN(3)) dut (
    .clk(clk), .reset(reset), .start(start0), .car_cont(cnt0), .data_in(data0),
    .cont_rst(rst0), .cont_en(en0), .tx(tx0), .busy(busy0), .done(done0)
  );

  uart_tx_seq #(.CLKS_PER_BIT(CPB), .MSG_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .car_cont(cnt1), .data_in(data1),
    .cont_rst(rst1), .cont_en(en1), .tx(tx1), .busy(busy1), .done(done1)
  );

  // downstream character counters and message ROMs
  assign data0 = rom0[cnt0];
  assign data1 = rom1[cnt1];
  always @(posedge clk) begin
    if (rst0) cnt0 <= 6'd0; else if (en0) cnt0 <= cnt0 + 6'd1;
    if (rst1) cnt1 <= 6'd0; else if (en1) cnt1 <= cnt1 + 6'd1;
  end

  // ---------------- waveform model ----------------
  rec_t q0[$], q1[$];
  logic pend0 = 1'b0, pend1 = 1'b0;

  function automatic void push(input int d, input rec_t r, input int n);
    for (int i = 0; i < n; i++)
      if (d == 0) q0.push_back(r); else q1.push_back(r);
  endfunction

  function automatic void build(input int d);
    int len;
    logic [7:0] b;
    len = (d == 0) ? 3 : 1;
    push(d, 5'b11010, 1);
    for (int c = 0; c < len; c++) begin
      b = (d == 0) ? rom0[c] : rom1[c];
      push(d, 5'b11000, 1);
      push(d, 5'b10000, CPB);
      for (int i = 0; i < 8; i++) push(d, {1'b1, b[i], 3'b000}, CPB);
`ifdef UART_TX_PARITY_EN
      push(d, {1'b1, ^b, 3'b000}, CPB);
`endif
      push(d, 5'b11000, CPB);
      push(d, {4'b1100, (c != len - 1)}, 1);
    end
    push(d, 5'b11100, 1);
  endfunction

  task automatic step(input int d, input rec_t act, input logic st, input logic rs);
    rec_t e;
    e = IDLE_R;
    if (d == 0) begin
      if (pend0) q0.delete(); else if (q0.size() > 0) e = q0.pop_front();
    end else begin
      if (pend1) q1.delete(); else if (q1.size() > 0) e = q1.pop_front();
    end
    total++;
    if (act !== e) begin
      bad++;
      if (shown < 20)
        $display("FAIL cycle dut%0d t=%0t busy/tx/done/rst/en got=%b want=%b", d, $time, act, e);
      shown++;
    end
    if (d == 0) pend0 = rs; else pend1 = rs;
    if (!rs && !e.busy && st) build(d);
  endtask

  always @(negedge clk) begin
    step(0, {busy0, tx0, done0, rst0, en0}, start0, reset);
    step(1, {busy1, tx1, done1, rst1, en1}, start1, reset);
  end

  // ---------------- observation of message-level quantities ----------------
  int bcnt0 = 0, len0 = 0, msgs0 = 0, encnt0 = 0, donecnt0 = 0, doneidx0 = 0, idle0 = 0, gap0 = 0;
  int bcnt1 = 0, len1 = 0, msgs1 = 0, encnt1 = 0, run1 = 0, maxrun1 = 0;
  logic bd0 = 1'b0, bd1 = 1'b0;
  logic txcap0 [0:255];

  always @(negedge clk) begin
    if (busy0 === 1'b1) begin
      if (!bd0) begin encnt0 = 0; donecnt0 = 0; gap0 = idle0; end
      if (bcnt0 < 256) txcap0[bcnt0] = tx0;
      if (en0) encnt0++;
      if (done0) begin donecnt0++; doneidx0 = bcnt0; end
      bcnt0++;
      idle0 = 0;
    end else begin
      if (bd0) begin len0 = bcnt0; bcnt0 = 0; msgs0++; end
      idle0++;
    end
    bd0 = (busy0 === 1'b1);

    if (busy1 === 1'b1) begin
      if (!bd1) begin encnt1 = 0; run1 = 0; maxrun1 = 0; end
      if (en1) encnt1++;
      if (tx1 == 1'b0) run1++; else run1 = 0;
      if (run1 > maxrun1) maxrun1 = run1;
      bcnt1++;
    end else if (bd1) begin
      len1 = bcnt1; bcnt1 = 0; msgs1++;
    end
    bd1 = (busy1 === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse0();
    cyc(1); start0 = 1'b1; cyc(1); start0 = 1'b0;
  endtask

  task automatic wait_msgs(input int d, input int target, input int budget);
    int n;
    n = 0;
    while ((((d == 0) ? msgs0 : msgs1) < target) && n < budget) begin cyc(1); n++; end
    chk($sformatf("wait_msgs%0d", d), (((d == 0) ? msgs0 : msgs1) >= target) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin rom0[i] = 8'hFF; rom1[i] = 8'h00; end
    rom0[0] = 8'h55;
`ifdef UART_TX_PARITY_EN
    rom0[1] = 8'h07;
`else
    rom0[1] = 8'hA3;
`endif
    rom0[2] = 8'h0F;

    cyc(3);
    reset = 1'b0;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);

    // single message on both instances
    cyc(2);
    start0 = 1'b1; start1 = 1'b1;
    cyc(1);
    start0 = 1'b0; start1 = 1'b0;
    wait_msgs(0, 1, 400);
    wait_msgs(1, 1, 400);
    chk("busy_len3", len0, BUSY3);
    chk("cont_en_cnt3", encnt0, 2);
    chk("done_cnt3", donecnt0, 1);
    chk("done_last", doneidx0, BUSY3 - 1);
    chk("c0_start_bit", txcap0[3], 0);
    chk("c0_bit0", txcap0[7], 1);
    chk("c0_bit1", txcap0[11], 0);
`ifdef UART_TX_PARITY_EN
    chk("par_55", txcap0[39], 0);
    chk("par_07", txcap0[85], 1);
`else
    chk("c1_bit0", txcap0[49], 1);
    chk("c1_bit2", txcap0[57], 0);
`endif
    chk("busy_len1", len1, BUSY1);
    chk("cont_en_cnt1", encnt1, 0);
    chk("tx_low_run1", maxrun1, LOW1);

    // start held high across DONE: back-to-back messages with one idle cycle
    cyc(3);
    start0 = 1'b1;
    wait_msgs(0, 2, 400);
    cyc(20);
    start0 = 1'b0;
    wait_msgs(0, 3, 400);
    chk("gap_after_done", gap0, 1);
    chk("busy_len_b2b", len0, BUSY3);

    // start pulses while busy are ignored
    cyc(4);
    pulse0();
    cyc(30);
    pulse0();
    cyc(30);
    start0 = 1'b1; cyc(2); start0 = 1'b0;
    wait_msgs(0, 4, 400);
    cyc(10);
    chk("ignored_starts", msgs0, 4);
    chk("idle_after", busy0, 0);

    // reset during data of character 1, then restart from character 0
    pulse0();
    n = 0;
    while (!(busy0 && bcnt0 >= 55) && n < 400) begin cyc(1); n++; end
    chk("reach_char1", (busy0 && bcnt0 >= 55) ? 1 : 0, 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_tx", tx0, 1);
    chk("mid_rst_en", en0, 0);
    reset = 1'b0;
    cyc(3);
    pulse0();
    wait_msgs(0, 6, 400);
    chk("restart_len", len0, BUSY3);
    chk("restart_c0_bit1", txcap0[11], 0);
    chk("restart_en_cnt", encnt0, 2);
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter MSG_LEN, default 32, characters per message; legal range 1..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level, sampled only in IDLE; high starts one message.
REQ-006 car_cont  input  6  current character index from the downstream character counter.
REQ-007 data_in  input  8  message byte addressed by car_cont; combinationally valid in the same cycle car_cont changes.
REQ-008 cont_rst  output  1  one-cycle pulse clearing the character counter.
REQ-009 cont_en  output  1  one-cycle pulse incrementing the character counter.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at message end.

Function
REQ-013 FSM states: IDLE, CLEAR, LOAD, START, DATA, PARITY, STOP, NEXT, DONE.
REQ-014 IDLE: tx=1; start=1 -> CLEAR; otherwise stay.
REQ-015 CLEAR: cont_rst=1 for exactly this cycle -> LOAD.
REQ-016 LOAD: latch data_in into shift register, clear bit-period and bit-index counters -> START; lasts 1 cycle.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-018 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit 7 -> PARITY if enabled, else STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles -> NEXT.
REQ-020 NEXT (1 cycle): if car_cont == MSG_LEN-1 -> DONE with cont_en=0; else cont_en=1 -> LOAD.
REQ-021 DONE (1 cycle): done=1, tx=1 -> IDLE.
REQ-022 Bit-period counter is 16 bits, counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary; bit-index counter is 3 bits.
REQ-023 tx is driven from a register; no combinational glitches.
REQ-024 Cycles per character = 10*CLKS_PER_BIT + 2 (LOAD + NEXT), or 11*CLKS_PER_BIT + 2 with parity.
REQ-025 busy duration per message = 2 + MSG_LEN * (cycles per character).
REQ-026 start while busy is ignored; start held high through DONE begins a new message in the cycle after return to IDLE.
REQ-027 MSG_LEN=1: no cont_en pulse is issued; single character then DONE.
REQ-028 Exactly MSG_LEN-1 cont_en pulses and one cont_rst pulse per message.

Reset
REQ-029 reset=1 forces IDLE on the next edge from any state, including mid-bit.
REQ-030 Reset values: tx=1, busy=0, done=0, cont_en=0, cont_rst=0, all internal counters 0, shift register 0.
REQ-031 A character truncated by reset is not resumed; the next start restarts the message at index 0.

Configuration
REQ-032 Macro UART_TX_PARITY_EN: when defined, PARITY state transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-033 Without UART_TX_PARITY_EN: PARITY state and parity logic are absent; DATA -> STOP directly.

Verification (CLKS_PER_BIT=4, MSG_LEN=3 unless stated)
REQ-034 Reset mid-DATA of char 1 -> next edge tx=1, busy=0, no cont_en; following start -> cont_rst pulse, tx resumes from char 0.
REQ-035 start pulse, ROM {0x55,0xA3,0x0F} -> tx per char: 0, data LSB first, 1, each 4 cycles; busy high 128 cycles; 2 cont_en pulses; done once in the last busy cycle.
REQ-036 MSG_LEN=1, data 0x00 -> tx low 36 cycles then high; zero cont_en; busy 44 cycles.
REQ-037 start held high across DONE -> second message begins 1 cycle after IDLE; start pulses during busy -> no effect.
REQ-038 UART_TX_PARITY_EN defined, data 0x55 -> parity bit 0; data 0x07 -> parity bit 1; busy 140 cycles for 3 chars.
